// File: rtl/riscv_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_wb_stage_if
// Description : MEM->WB instruction slot, data-memory load response and
//               WB->commit result bundle for the RV64I write-back stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_wb_stage_if;
    logic [63:0] mem_pc;
    logic [31:0] mem_inst;
    logic [63:0] mem_alu_result;
    logic [4:0]  mem_rd_addr;
    logic        mem_wr_en;
    logic        mem_is_load;
    logic        mem_valid;
    logic        dmem_rsp_valid;
    logic [63:0] dmem_rsp_data;
    logic        flush;
    logic        wb_stall;
    logic [63:0] wb_pc;
    logic [31:0] wb_inst;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_wr_en;
    logic        wb_valid;
    logic        wb_exc_valid;
    logic [3:0]  wb_exc_cause;

    modport master (
        output mem_pc, mem_inst, mem_alu_result, mem_rd_addr, mem_wr_en,
               mem_is_load, mem_valid, dmem_rsp_valid, dmem_rsp_data, flush,
        input  wb_stall, wb_pc, wb_inst, wb_data, wb_rd_addr, wb_wr_en,
               wb_valid, wb_exc_valid, wb_exc_cause
    );

    modport slave (
        input  mem_pc, mem_inst, mem_alu_result, mem_rd_addr, mem_wr_en,
               mem_is_load, mem_valid, dmem_rsp_valid, dmem_rsp_data, flush,
        output wb_stall, wb_pc, wb_inst, wb_data, wb_rd_addr, wb_wr_en,
               wb_valid, wb_exc_valid, wb_exc_cause
    );
endinterface
`default_nettype wire

// File: rtl/riscv_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : riscv_wb_stage
// Description : RV64I write-back stage: load alignment/extension, load-response
//               stall with timeout, load exception flagging, result register.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_wb_stage #(
    parameter int LOAD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    riscv_wb_stage_if.slave  bus
);
    localparam int                CNT_W    = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);
    localparam logic [0:0]        ST_RUN   = 1'b0;
    localparam logic [0:0]        ST_WAIT  = 1'b1;
    localparam logic [3:0]        CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0]        CAUSE_MISALIGN  = 4'd4;
    localparam logic [3:0]        CAUSE_ACC_FAULT = 4'd5;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]  funct3;
    logic [2:0]  off;
    logic        ld;
    logic        ld_slot;
    logic        misalign_raw;
    logic        exc_illegal;
    logic        exc_misalign;
    logic        exc_any;
    logic        timeout;
    logic        stall;
    logic        to_fault;
    logic        retire;
    logic [63:0] shifted;
    logic [63:0] load_data;
    logic [63:0] result;
    logic [3:0]  cause;

    logic [63:0] wb_pc_q, wb_data_q;
    logic [31:0] wb_inst_q;
    logic [4:0]  wb_rd_addr_q;
    logic        wb_wr_en_q, wb_valid_q, wb_exc_valid_q;
    logic [3:0]  wb_exc_cause_q;

    assign funct3  = bus.mem_inst[14:12];
    assign off     = bus.mem_alu_result[2:0];
    assign ld_slot = bus.mem_valid & bus.mem_is_load;
    assign ld      = ld_slot & ~bus.flush;

    always_comb begin
        misalign_raw = 1'b0;
        case (funct3)
            3'b001, 3'b101: misalign_raw = off[0];
            3'b010, 3'b110: misalign_raw = |off[1:0];
            3'b011:         misalign_raw = |off;
            default:        misalign_raw = 1'b0;
        endcase
    end

    assign exc_illegal  = ld_slot & (funct3 == 3'b111);
    assign exc_misalign = ld_slot & ~exc_illegal & misalign_raw;
    assign exc_any      = exc_illegal | exc_misalign;

    // Doubleword response shifted so the addressed byte lands in bits [7:0].
    assign shifted = bus.dmem_rsp_data >> {off, 3'b000};

    always_comb begin
        load_data = bus.dmem_rsp_data;
        case (funct3)
            3'b000:  load_data = {{56{shifted[7]}},  shifted[7:0]};
            3'b100:  load_data = {56'd0,             shifted[7:0]};
            3'b001:  load_data = {{48{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {48'd0,             shifted[15:0]};
            3'b010:  load_data = {{32{shifted[31]}}, shifted[31:0]};
            3'b110:  load_data = {32'd0,             shifted[31:0]};
            default: load_data = bus.dmem_rsp_data;
        endcase
    end

    assign result = bus.mem_is_load ? load_data : bus.mem_alu_result;
    assign cause  = exc_illegal ? CAUSE_ILLEGAL :
                    exc_misalign ? CAUSE_MISALIGN : CAUSE_ACC_FAULT;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (stall) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic; a response arriving in the timeout cycle wins over the fault
    always_comb begin
        timeout  = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);
        stall    = ld & ~exc_any & ~bus.dmem_rsp_valid & ~timeout;
        to_fault = ld & ~exc_any & ~bus.dmem_rsp_valid & timeout;
        retire   = bus.mem_valid & ~bus.flush & ~stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q     <= 1'b0;
            wb_exc_valid_q <= 1'b0;
        end else begin
            wb_valid_q     <= retire;
            wb_exc_valid_q <= retire & (exc_any | to_fault);
        end
    end

    always_ff @(posedge clk) begin
        if (retire) begin
            wb_pc_q        <= bus.mem_pc;
            wb_inst_q      <= bus.mem_inst;
            wb_data_q      <= result;
            wb_rd_addr_q   <= bus.mem_rd_addr;
            wb_wr_en_q     <= bus.mem_wr_en & (bus.mem_rd_addr != 5'd0) & ~exc_any & ~to_fault;
            wb_exc_cause_q <= cause;
        end
    end

    assign bus.wb_stall     = stall;
    assign bus.wb_pc        = wb_pc_q;
    assign bus.wb_inst      = wb_inst_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_rd_addr   = wb_rd_addr_q;
    assign bus.wb_wr_en     = wb_wr_en_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_exc_valid = wb_exc_valid_q;
    assign bus.wb_exc_cause = wb_exc_cause_q;
endmodule
`default_nettype wire

// File: tb/tb_riscv_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_wb_stage
// Description : Randomized scoreboard bench for riscv_wb_stage (LOAD_TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_wb_stage;
    localparam int T = 4;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] data;
        logic [4:0]  rd;
        logic        wren;
        logic        exc;
        logic [3:0]  cause;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    riscv_wb_stage_if bus();

    riscv_wb_stage #(.LOAD_TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: outcome of one instruction from the load rules, by byte arithmetic.
    function automatic void model(input logic [31:0] inst, input logic [63:0] alu,
                                  input logic [63:0] rsp, input logic isld,
                                  input logic wr, input logic [4:0] rd,
                                  input int rsp_cyc, input int fl_cyc,
                                  output logic retire, output int stalls,
                                  output exp_t e);
        int   f3, off, nbytes, end_cyc;
        logic [63:0] v;
        logic [7:0]  b [8];
        f3      = int'(inst[14:12]);
        off     = int'(alu[2:0]);
        nbytes  = 1 << (f3 % 4);
        end_cyc = 0;
        e.exc   = 1'b0;
        e.cause = 4'd0;
        e.data  = alu;
        if (isld) begin
            if (f3 == 7) begin
                e.exc = 1'b1; e.cause = 4'd2;
            end else if ((off % nbytes) != 0) begin
                e.exc = 1'b1; e.cause = 4'd4;
            end else begin
                if (rsp_cyc >= 0 && rsp_cyc <= T - 1) end_cyc = rsp_cyc;
                else begin
                    end_cyc = T - 1; e.exc = 1'b1; e.cause = 4'd5;
                end
                for (int i = 0; i < 8; i++) b[i] = rsp[8*i +: 8];
                v = 64'd0;
                for (int j = 0; j < nbytes; j++) v = v | (64'(b[off + j]) << (8 * j));
                if (f3 < 4 && nbytes < 8 && v[8*nbytes-1]) v = v | (~64'd0 << (8 * nbytes));
                e.data = v;
            end
        end
        if (fl_cyc >= 0 && fl_cyc <= end_cyc) begin
            retire = 1'b0; stalls = fl_cyc;
        end else begin
            retire = 1'b1; stalls = end_cyc;
        end
        e.inst = inst;
        e.rd   = rd;
        e.wren = wr && (rd != 5'd0) && !e.exc;
    endfunction

    task automatic issue(input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] alu,
                         input logic [4:0] rd, input logic wr, input logic isld,
                         input logic [63:0] rsp, input int rsp_cyc, input int fl_cyc);
        logic retire, done;
        int   exp_stalls, stalls, k;
        exp_t e;
        model(inst, alu, rsp, isld, wr, rd, rsp_cyc, fl_cyc, retire, exp_stalls, e);
        e.pc = pc;
        if (retire) sb_q.push_back(e);
        bus.mem_pc = pc; bus.mem_inst = inst; bus.mem_alu_result = alu;
        bus.mem_rd_addr = rd; bus.mem_wr_en = wr; bus.mem_is_load = isld;
        bus.mem_valid = 1'b1; bus.dmem_rsp_data = rsp;
        k = 0; stalls = 0; done = 1'b0;
        while (!done) begin
            bus.dmem_rsp_valid = (k == rsp_cyc) || (!isld && $urandom_range(0, 1) == 1);
            bus.flush = (k == fl_cyc);
            @(negedge clk);
            if (k >= 1) chk("bubble_during_stall", 64'(bus.wb_valid), 64'd0);
            if (bus.wb_stall) stalls++;
            if (!bus.wb_stall || bus.flush) done = 1'b1;
            if (k > T + 1) begin
                chk("stall_bound", 64'(k), 64'(T));
                done = 1'b1;
            end
            @(posedge clk); #1;
            k++;
        end
        chk("stall_cycles", 64'(stalls), 64'(exp_stalls));
        bus.mem_valid = 1'b0; bus.flush = 1'b0; bus.dmem_rsp_valid = 1'b0;
    endtask

    task automatic idle(input logic stray_rsp);
        bus.mem_valid = 1'b0; bus.flush = 1'b0;
        bus.dmem_rsp_valid = stray_rsp;
        @(posedge clk); #1;
        bus.dmem_rsp_valid = 1'b0;
    endtask

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd);
        return {17'($urandom), f3, rd, 7'h03};
    endfunction

    // Monitor: every retirement must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wb_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_retire", 64'(bus.wb_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("wb_pc", bus.wb_pc, e.pc);
                    chk("wb_inst", 64'(bus.wb_inst), 64'(e.inst));
                    chk("wb_rd_addr", 64'(bus.wb_rd_addr), 64'(e.rd));
                    chk("wb_wr_en", 64'(bus.wb_wr_en), 64'(e.wren));
                    chk("wb_exc_valid", 64'(bus.wb_exc_valid), 64'(e.exc));
                    if (e.exc) chk("wb_exc_cause", 64'(bus.wb_exc_cause), 64'(e.cause));
                    else       chk("wb_data", bus.wb_data, e.data);
                end
            end else if (bus.wb_exc_valid) begin
                chk("exc_without_valid", 64'(bus.wb_exc_valid), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] alu, rsp;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        isld;
        int          rc, fc;
        checks = 0; errors = 0;
        rst_n = 1'b0;
        bus.mem_pc = '0; bus.mem_inst = mk_inst(3'b011, 5'd1);
        bus.mem_alu_result = 64'h1000; bus.mem_rd_addr = 5'd1; bus.mem_wr_en = 1'b1;
        bus.mem_is_load = 1'b1; bus.mem_valid = 1'b1; bus.dmem_rsp_valid = 1'b0;
        bus.dmem_rsp_data = '0; bus.flush = 1'b0;
        #1;
        chk("reset_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("reset_wb_exc_valid", 64'(bus.wb_exc_valid), 64'd0);
        chk("reset_stall_comb", 64'(bus.wb_stall), 64'd1);
        bus.mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Non-load pass-through, then rd=0 suppresses the write
        issue(64'h100, 32'h00000013, 64'h123456789ABCDEF0, 5'd5, 1'b1, 1'b0, '0, -1, -1);
        issue(64'h104, 32'h00000013, 64'h123456789ABCDEF0, 5'd0, 1'b1, 1'b0, '0, -1, -1);
        // Same-cycle response extraction
        issue(64'h108, mk_inst(3'b000, 5'd6), 64'h2003, 5'd6, 1'b1, 1'b1, 64'h0000000080000000, 0, -1);
        issue(64'h10C, mk_inst(3'b100, 5'd6), 64'h2003, 5'd6, 1'b1, 1'b1, 64'h0000000080000000, 0, -1);
        issue(64'h110, mk_inst(3'b010, 5'd7), 64'h3004, 5'd7, 1'b1, 1'b1, 64'hDEADBEEF00000000, 0, -1);
        issue(64'h114, mk_inst(3'b110, 5'd7), 64'h3004, 5'd7, 1'b1, 1'b1, 64'hDEADBEEF00000000, 0, -1);
        // Misaligned and reserved encodings
        issue(64'h118, mk_inst(3'b011, 5'd8), 64'h4004, 5'd8, 1'b1, 1'b1, '0, -1, -1);
        issue(64'h11C, mk_inst(3'b001, 5'd8), 64'h4001, 5'd8, 1'b1, 1'b1, '0, -1, -1);
        issue(64'h120, mk_inst(3'b111, 5'd8), 64'h4000, 5'd8, 1'b1, 1'b1, '0, -1, -1);
        // Late response, timeout, response in the timeout cycle
        issue(64'h124, mk_inst(3'b011, 5'd9), 64'h5000, 5'd9, 1'b1, 1'b1, 64'h0123456789ABCDEF, 3, -1);
        issue(64'h128, mk_inst(3'b011, 5'd9), 64'h5008, 5'd9, 1'b1, 1'b1, 64'h0123456789ABCDEF, -1, -1);
        issue(64'h12C, mk_inst(3'b001, 5'd9), 64'h5006, 5'd9, 1'b1, 1'b1, 64'h8001000000000000, 2, -1);
        // Flush in stall cycle 2, then a stray response
        issue(64'h130, mk_inst(3'b011, 5'd10), 64'h6000, 5'd10, 1'b1, 1'b1, 64'h55, -1, 2);
        idle(1'b1);
        issue(64'h134, 32'h00000013, 64'hCAFE, 5'd11, 1'b1, 1'b0, '0, -1, -1);

        // Reset while waiting for a response
        bus.mem_pc = 64'h138; bus.mem_inst = mk_inst(3'b011, 5'd12);
        bus.mem_alu_result = 64'h7000; bus.mem_rd_addr = 5'd12; bus.mem_wr_en = 1'b1;
        bus.mem_is_load = 1'b1; bus.mem_valid = 1'b1; bus.dmem_rsp_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("wait_stall", 64'(bus.wb_stall), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midwait_reset_valid", 64'(bus.wb_valid), 64'd0);
        chk("midwait_reset_exc", 64'(bus.wb_exc_valid), 64'd0);
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        idle(1'b1);
        issue(64'h13C, mk_inst(3'b010, 5'd13), 64'h7004, 5'd13, 1'b1, 1'b1, 64'h7FFFFFFF00000000, 2, -1);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            isld = ($urandom_range(0, 9) < 7);
            f3   = 3'($urandom_range(0, 7));
            rd   = 5'($urandom);
            alu  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) alu[2:0] = alu[2:0] & ~3'((1 << (f3 % 4)) - 1);
            rsp  = {$urandom, $urandom};
            rc   = $urandom_range(0, 5) - 1;
            fc   = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, 3)) : -1;
            issue({$urandom, $urandom}, mk_inst(f3, rd), alu, rd, 1'($urandom), isld, rsp, rc, fc);
            if ($urandom_range(0, 3) == 0) idle(1'($urandom));
        end

        repeat (3) idle(1'b0);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
